// File: rtl/config_loader_pkg.sv
// rtl/config_loader_pkg.sv - shared PE grid sizes, record field widths and loader state enum
package config_loader_pkg;

    // PE array geometry shared with the array itself
    localparam int CFG_PE_ROWS    = 4;
    localparam int CFG_PE_COLUMNS = 4;

    // Row/column fields carry one spare bit so out-of-grid indices stay visible
    localparam int ROW_W = $clog2(CFG_PE_ROWS) + 1;
    localparam int COL_W = $clog2(CFG_PE_COLUMNS) + 1;

    // Operand source selector width and opcode width
    localparam int IN_W  = 4;
    localparam int OP_W  = 5;
    localparam int DST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2,
        ST_RUN  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/config_coverage.sv
// rtl/config_coverage.sv - per-PE written bitmap with all-covered reduction
module config_coverage #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ROW_IW = 3,
    parameter int COL_IW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              set_en,
    input  logic [ROW_IW-1:0] set_row,
    input  logic [COL_IW-1:0] set_col,
    output logic              all_set
);

    logic [ROWS*COLS-1:0] bitmap_q;

    // Mark a PE once any valid record lands on it; clear starts a new session
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bitmap_q <= '0;
        end else if (set_en) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (set_row == ROW_IW'(r) && set_col == COL_IW'(c)) begin
                        bitmap_q[r*COLS + c] <= 1'b1;
                    end
                end
            end
        end
    end

    assign all_set = &bitmap_q;

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - streams config records into the PE array and arms execution
import config_loader_pkg::*;

module config_loader #(
    parameter int PE_ROW_SIZE    = CFG_PE_ROWS,
    parameter int PE_COLUMN_SIZE = CFG_PE_COLUMNS,
    parameter int CONTEXT_SIZE   = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ENTRY_W        = 8,
    parameter int CTX_W          = $clog2(CONTEXT_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ENTRY_W-1:0]    num_entries,
    input  logic [CTX_W-1:0]      ctx_max_id,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROW_W-1:0]      in_row,
    input  logic [COL_W-1:0]      in_col,
    input  logic [CTX_W-1:0]      in_ctx,
    input  logic [IN_W-1:0]       in_src1,
    input  logic [IN_W-1:0]       in_src2,
    input  logic [DST_W-1:0]      in_dst,
    input  logic [OP_W-1:0]       in_op,
    input  logic [DATA_WIDTH-1:0] in_const,
    output logic [ROW_W-1:0]      config_PE_row_index,
    output logic [COL_W-1:0]      config_PE_column_index,
    output logic [CTX_W-1:0]      config_index,
    output logic [IN_W-1:0]       config_input_PE_index_1,
    output logic [IN_W-1:0]       config_input_PE_index_2,
    output logic [DST_W-1:0]      config_output_PE_index,
    output logic [OP_W-1:0]       config_op,
    output logic [DATA_WIDTH-1:0] config_const_data,
    output logic                  write_config_data,
    output logic                  start_exec,
    output logic [CTX_W-1:0]      mapping_context_max_id,
    input  logic                  exec_stop,
    output logic                  busy,
    output logic                  done,
    output logic                  err_range,
    output logic                  err_incomplete
);

    loader_state_t    state_q;
    loader_state_t    state_d;
    logic [ENTRY_W-1:0] remaining_q;
    logic             accept;
    logic             in_range;
    logic             all_set;
    logic             session_start;

    assign accept        = in_valid & in_ready;
    assign session_start = (state_q == ST_IDLE) && load_start;
    assign in_range      = (int'(in_row) < PE_ROW_SIZE) &&
                           (int'(in_col) < PE_COLUMN_SIZE) &&
                           (in_ctx <= mapping_context_max_id);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded handshake/status outputs
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        start_exec = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // An empty session accepts nothing and falls straight through to ARM
                in_ready = (remaining_q != '0);
                if (remaining_q == '0) begin
                    state_d = ST_ARM;
                end else if (in_valid && remaining_q == ENTRY_W'(1)) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = all_set ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                start_exec = 1'b1;
                if (exec_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session latches, registered record output, one-cycle strobes and sticky errors
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q             <= '0;
            mapping_context_max_id  <= '0;
            config_PE_row_index     <= '0;
            config_PE_column_index  <= '0;
            config_index            <= '0;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_output_PE_index  <= '0;
            config_op               <= '0;
            config_const_data       <= '0;
            write_config_data       <= 1'b0;
            done                    <= 1'b0;
            err_range               <= 1'b0;
            err_incomplete          <= 1'b0;
        end else begin
            write_config_data <= 1'b0;
            done              <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        remaining_q            <= num_entries;
                        mapping_context_max_id <= ctx_max_id;
                        err_range              <= 1'b0;
                        err_incomplete         <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        remaining_q <= remaining_q - ENTRY_W'(1);
                        if (in_range) begin
                            write_config_data       <= 1'b1;
                            config_PE_row_index     <= in_row;
                            config_PE_column_index  <= in_col;
                            config_index            <= in_ctx;
                            config_input_PE_index_1 <= in_src1;
                            config_input_PE_index_2 <= in_src2;
                            config_output_PE_index  <= in_dst;
                            config_op               <= in_op;
                            config_const_data       <= in_const;
                        end else begin
                            err_range <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (!all_set) begin
                        err_incomplete <= 1'b1;
                        done           <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (exec_stop) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    config_coverage #(
        .ROWS   (PE_ROW_SIZE),
        .COLS   (PE_COLUMN_SIZE),
        .ROW_IW (ROW_W),
        .COL_IW (COL_W)
    ) u_coverage (
        .clk     (clk),
        .reset   (reset),
        .clear   (session_start),
        .set_en  (accept && in_range),
        .set_row (in_row),
        .set_col (in_col),
        .all_set (all_set)
    );

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - scoreboard bench for config_loader load/arm/run sessions
module tb_config_loader;
    import config_loader_pkg::*;

    localparam int CTX_W   = 3;
    localparam int ENTRY_W = 8;
    localparam int DW      = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_start;
    logic [ENTRY_W-1:0] num_entries;
    logic [CTX_W-1:0]   ctx_max_id;
    logic               in_valid;
    logic               in_ready;
    logic [ROW_W-1:0]   in_row;
    logic [COL_W-1:0]   in_col;
    logic [CTX_W-1:0]   in_ctx;
    logic [IN_W-1:0]    in_src1;
    logic [IN_W-1:0]    in_src2;
    logic [DST_W-1:0]   in_dst;
    logic [OP_W-1:0]    in_op;
    logic [DW-1:0]      in_const;
    logic [ROW_W-1:0]   config_PE_row_index;
    logic [COL_W-1:0]   config_PE_column_index;
    logic [CTX_W-1:0]   config_index;
    logic [IN_W-1:0]    config_input_PE_index_1;
    logic [IN_W-1:0]    config_input_PE_index_2;
    logic [DST_W-1:0]   config_output_PE_index;
    logic [OP_W-1:0]    config_op;
    logic [DW-1:0]      config_const_data;
    logic               write_config_data;
    logic               start_exec;
    logic [CTX_W-1:0]   mapping_context_max_id;
    logic               exec_stop;
    logic               busy;
    logic               done;
    logic               err_range;
    logic               err_incomplete;

    config_loader dut (
        .clk                     (clk),
        .reset                   (reset),
        .load_start              (load_start),
        .num_entries             (num_entries),
        .ctx_max_id              (ctx_max_id),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_row                  (in_row),
        .in_col                  (in_col),
        .in_ctx                  (in_ctx),
        .in_src1                 (in_src1),
        .in_src2                 (in_src2),
        .in_dst                  (in_dst),
        .in_op                   (in_op),
        .in_const                (in_const),
        .config_PE_row_index     (config_PE_row_index),
        .config_PE_column_index  (config_PE_column_index),
        .config_index            (config_index),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_output_PE_index  (config_output_PE_index),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .write_config_data       (write_config_data),
        .start_exec              (start_exec),
        .mapping_context_max_id  (mapping_context_max_id),
        .exec_stop               (exec_stop),
        .busy                    (busy),
        .done                    (done),
        .err_range               (err_range),
        .err_incomplete          (err_incomplete)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [CTX_W-1:0] ctx;
        logic [IN_W-1:0]  s1;
        logic [IN_W-1:0]  s2;
        logic [DST_W-1:0] dst;
        logic [OP_W-1:0]  op;
        logic [DW-1:0]    k;
        logic             exp_write;
    } rec_t;

    typedef logic [63:0] pk_t;

    rec_t tbl [17];
    rec_t cur [$];
    pk_t  sb [$];
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    int   done_cnt = 0;
    bit   start_seen = 0;

    function automatic pk_t pack_rec(rec_t r);
        return {6'd0, r.row, r.col, r.ctx, r.s1, r.s2, r.dst, r.op, r.k};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected record
    always @(negedge clk) begin
        if (write_config_data) begin
            strobes++;
            if (sb.size() == 0) begin
                check("strobe_unexpected", 1, 0);
            end else begin
                check("strobe_fields",
                      {6'd0, config_PE_row_index, config_PE_column_index, config_index,
                       config_input_PE_index_1, config_input_PE_index_2,
                       config_output_PE_index, config_op, config_const_data},
                      sb.pop_front());
            end
        end
        if (done) done_cnt++;
        if (start_exec) start_seen = 1;
    end

    task automatic start_load(int n, int cmax);
        num_entries = ENTRY_W'(n);
        ctx_max_id  = CTX_W'(cmax);
        load_start  = 1'b1;
        @(posedge clk); #1;
        load_start  = 1'b0;
    endtask

    task automatic send(rec_t r, int gap);
        bit acc = 0;
        in_row = r.row; in_col = r.col; in_ctx = r.ctx;
        in_src1 = r.s1; in_src2 = r.s2; in_dst = r.dst;
        in_op = r.op; in_const = r.k;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                if (r.exp_write) sb.push_back(pack_rec(r));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Runs one whole session from cur[] and checks ARM, RUN/abort and the end-of-session state
    task automatic session(int cmax, int gap, logic exp_run, logic exp_rerr, int exp_strobes);
        int n = cur.size();
        strobes = 0; done_cnt = 0; start_seen = 0;
        start_load(n, cmax);
        for (int i = 0; i < n; i++) send(cur[i], (i == n-1) ? 0 : gap);
        check("arm_start_exec", start_exec, 0);
        check("arm_busy", busy, 1);
        @(posedge clk); #1;
        if (exp_run) begin
            check("run_start_exec", start_exec, 1);
            load_start = 1'b1; num_entries = 8'd3;
            @(posedge clk); #1;
            load_start = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            check("run_ignores_load", start_exec, 1);
            check("ctx_max_latched", mapping_context_max_id, cmax);
            exec_stop = 1'b1;
            @(posedge clk); #1;
            exec_stop = 1'b0;
            check("stop_done", done, 1);
            check("stop_start_exec", start_exec, 0);
            check("stop_err_incomplete", err_incomplete, 0);
        end else begin
            check("abort_err_incomplete", err_incomplete, 1);
            check("abort_done", done, 1);
        end
        check("end_busy", busy, 0);
        check("err_range", err_range, exp_rerr);
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);
        check("strobe_count", strobes, exp_strobes);
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", done_cnt, 1);
        check("start_seen", start_seen, exp_run);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; load_start = 0; num_entries = 0; ctx_max_id = 0;
        in_valid = 0; in_row = 0; in_col = 0; in_ctx = 0; in_src1 = 0;
        in_src2 = 0; in_dst = 0; in_op = 0; in_const = 0; exec_stop = 0;

        // Vector table: one record per PE, then one off-grid record
        for (int i = 0; i < 16; i++) begin
            tbl[i].row = ROW_W'(i / 4);
            tbl[i].col = COL_W'(i % 4);
            tbl[i].ctx = CTX_W'(i % 2);
            tbl[i].s1  = IN_W'(i);
            tbl[i].s2  = IN_W'(15 - i);
            tbl[i].dst = DST_W'(i * 3);
            tbl[i].op  = OP_W'(i + 3);
            tbl[i].k   = 32'hA500_0000 + 32'(i) * 32'h0001_1111;
            tbl[i].exp_write = 1'b1;
        end
        tbl[16] = tbl[5];
        tbl[16].row = 3'd5;
        tbl[16].exp_write = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_write", write_config_data, 0);
        check("rst_start_exec", start_exec, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {done, err_range, err_incomplete}, 0);
        check("rst_fields", {config_op, config_const_data, mapping_context_max_id}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full load, back to back
        cur.delete();
        for (int i = 0; i < 16; i++) cur.push_back(tbl[i]);
        session(1, 0, 1, 0, 16);

        // exec_stop while idle does nothing
        exec_stop = 1'b1;
        @(posedge clk); #1;
        exec_stop = 1'b0;
        @(posedge clk); #1;
        check("idle_stop_done", done, 0);
        check("idle_stop_busy", busy, 0);

        // Backpressure: in_valid alternates
        session(1, 1, 1, 0, 16);

        // Off-grid record in the middle
        cur.delete();
        for (int i = 0; i < 16; i++) begin
            if (i == 8) cur.push_back(tbl[16]);
            cur.push_back(tbl[i]);
        end
        session(1, 0, 1, 1, 16);

        // PE(3,3) missing
        cur.delete();
        for (int i = 0; i < 15; i++) cur.push_back(tbl[i]);
        session(1, 0, 0, 0, 15);

        // Reset while the eighth record is on offer
        strobes = 0;
        start_load(16, 1);
        for (int i = 0; i < 7; i++) send(tbl[i], 0);
        in_row = tbl[7].row; in_col = tbl[7].col; in_ctx = tbl[7].ctx;
        in_const = tbl[7].k; in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_write", write_config_data, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_strobes", strobes, 7);
        check("mid_rst_sb", sb.size(), 0);
        cur.delete();
        for (int i = 0; i < 16; i++) cur.push_back(tbl[i]);
        session(1, 0, 1, 0, 16);

        // Empty session: LOAD, ARM, then back to IDLE with incomplete flagged
        done_cnt = 0; start_seen = 0;
        start_load(0, 0);
        check("empty_load_busy", busy, 1);
        check("empty_load_ready", in_ready, 0);
        @(posedge clk); #1;
        check("empty_arm_busy", busy, 1);
        check("empty_arm_err", err_incomplete, 0);
        @(posedge clk); #1;
        check("empty_idle_busy", busy, 0);
        check("empty_err_incomplete", err_incomplete, 1);
        check("empty_done", done, 1);
        @(posedge clk); #1;
        check("empty_start_seen", start_seen, 0);
        check("empty_done_count", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Param PE_ROW_SIZE, default 4: number of PE rows.
REQ-002 Param PE_COLUMN_SIZE, default 4: number of PE columns.
REQ-003 Param CONTEXT_SIZE, default 8: number of contexts per PE; CTX_W = clog2(CONTEXT_SIZE).
REQ-004 Param DATA_WIDTH, default 32: width of the constant operand.
REQ-005 Param ENTRY_W, default 8: width of the entry counter.
REQ-006 The block SHALL use one clock, clk; reset is synchronous and active-high, on port reset.
REQ-007 clk  in  1  clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 load_start  in  1  begins a load session; sampled in IDLE only.
REQ-010 num_entries / ctx_max_id  in  ENTRY_W / CTX_W  record count / last context id; both latched at load_start.
REQ-011 in_valid / in_ready  in / out  1 / 1  config record handshake.
REQ-012 in_row, in_col, in_ctx, in_src1, in_src2, in_dst, in_op, in_const  in  ROW_W, COL_W, CTX_W, IN_W, IN_W, 4, OP_W, DATA_WIDTH  record fields.
REQ-013 config_PE_row_index, config_PE_column_index, config_index, config_input_PE_index_1/_2, config_output_PE_index, config_op, config_const_data  out  matching widths  registered record to array.
REQ-014 write_config_data / start_exec  out  1 / 1  config write strobe / execution enable to array.
REQ-015 mapping_context_max_id  out  CTX_W  latched ctx_max_id.
REQ-016 exec_stop  in  1  ends execution.
REQ-017 busy / done / err_range / err_incomplete  out  1 each  status.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, ARM, RUN.
REQ-019 IDLE->LOAD on load_start; latch num_entries and ctx_max_id; clear the PE coverage bitmap (PE_ROW_SIZE*PE_COLUMN_SIZE bits); clear done and both errors.
REQ-020 in_ready SHALL be 1 only in LOAD; a record is accepted when in_valid & in_ready.
REQ-021 Accepted record fields SHALL appear on the config_* outputs the next cycle, with write_config_data high for exactly that one cycle (latency 1).
REQ-022 A record with row >= PE_ROW_SIZE, col >= PE_COLUMN_SIZE, or ctx > ctx_max_id SHALL be consumed and counted but not written; err_range sets and stays set.
REQ-023 A valid write SHALL set the coverage bit for (row,col); duplicate writes are legal and the last one wins.
REQ-024 Remaining-entry counter decrements per acceptance; acceptance of the last entry SHALL move LOAD->ARM.
REQ-025 num_entries == 0 SHALL go LOAD->ARM on the next cycle with no acceptance.
REQ-026 ARM lasts exactly one cycle so the final write lands. If every coverage bit is set: ->RUN. Otherwise: set err_incomplete, pulse done, ->IDLE.
REQ-027 start_exec SHALL be high throughout RUN and low in all other states.
REQ-028 RUN->IDLE on exec_stop, with done pulsed for one cycle. exec_stop outside RUN is ignored.
REQ-029 load_start outside IDLE SHALL be ignored.
REQ-030 busy = (state != IDLE).
REQ-031 err_range alone SHALL NOT block RUN.

Reset
REQ-032 On reset, the state SHALL be IDLE and every output 0: in_ready, write_config_data, start_exec, config_* fields, mapping_context_max_id, status flags.
REQ-033 Reset mid-LOAD or mid-RUN SHALL abort immediately, with no further write strobe and start_exec low in the following cycle.

Structure
REQ-034 State enum, field widths (ROW_W, COL_W, IN_W, OP_W) and PE grid sizes SHALL live in the shared parameter package used by the array.
REQ-035 The coverage bitmap with its all-set reduction SHALL be the single sub-module config_coverage.

Verification
REQ-036 Full load: num_entries=16 covering all 4x4 PEs, ctx_max_id=1 -> 16 one-cycle write strobes with fields matching; ARM for 1 cycle; start_exec=1 until exec_stop; done pulses once.
REQ-037 Backpressure: in_valid toggled 1/0 every cycle with 16 entries -> exactly 16 strobes; no duplicated or dropped record.
REQ-038 Range error: one record with row=5 among 17 records -> 16 strobes; err_range=1; RUN is still entered.
REQ-039 Incomplete: 15 entries with PE(3,3) missing -> err_incomplete=1; done pulse; start_exec never asserted.
REQ-040 Reset at entry 7 of 16 -> in_ready=0, write_config_data=0 next cycle; a fresh load then completes normally.
REQ-041 num_entries=0 -> IDLE, LOAD, ARM, then err_incomplete=1, returning to IDLE within 3 cycles of load_start.
